// File: rtl/spi_regs_pkg.sv
// rtl/spi_regs_pkg.sv - shared types and command-byte layout for the SPI register decoder
package spi_regs_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CAP = 2'd1,
        DATA   = 2'd2
    } state_e;

    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_HI_BIT   = 6;
    localparam int CMD_ADDR_MSB = 5;
    localparam int ADDR_W       = 6;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - multi-flop synchroniser with selectable reset value
module sync_2ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_instr_decoder.sv
// rtl/spi_instr_decoder.sv - turns SPI command/data byte pairs into register read/write strobes
module spi_instr_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = spi_regs_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              reg_read,
    output logic              reg_write,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_hi,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic              proto_err
);
    import spi_regs_pkg::*;

    state_e state, next_state;
    logic   cs_sync;
    logic   is_wr;
    logic   latch_cmd, set_read, set_write, capture, drop;

    // Chain idles high so a reset with chip select low still reads as "no frame" briefly.
    sync_2ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (cs_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // IDLE with reg_read high is the read-pending cycle; rdata is sampled in RD_CAP.
    always_comb begin
        next_state = state;
        latch_cmd  = 1'b0;
        set_read   = 1'b0;
        set_write  = 1'b0;
        capture    = 1'b0;
        drop       = 1'b0;
        if (cs_sync) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (reg_read) begin
                        next_state = RD_CAP;
                        drop       = byte_sync;
                    end else if (byte_sync) begin
                        latch_cmd = 1'b1;
                        if (data_in[CMD_WR_BIT]) begin
                            next_state = DATA;
                        end else begin
                            set_read = 1'b1;
                        end
                    end
                end
                RD_CAP: begin
                    capture    = 1'b1;
                    drop       = byte_sync;
                    next_state = DATA;
                end
                DATA: begin
                    if (byte_sync) begin
                        set_write  = is_wr;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= 8'h00;
            reg_read  <= 1'b0;
            reg_write <= 1'b0;
            reg_addr  <= '0;
            reg_hi    <= 1'b0;
            reg_wdata <= 8'h00;
            is_wr     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            reg_read  <= set_read;
            reg_write <= set_write;
            if (latch_cmd) begin
                reg_addr <= data_in[CMD_ADDR_MSB -: ADDR_W];
                reg_hi   <= data_in[CMD_HI_BIT];
                is_wr    <= data_in[CMD_WR_BIT];
            end
            if (set_write) begin
                reg_wdata <= data_in;
            end
            if (capture) begin
                data_out <= reg_rdata;
            end
            if (drop) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
